// File: rtl/program_loader.sv
// program_loader: serial byte-stream boot loader that fills instruction memory.
// Latency: each word is written one cycle after its 4th byte is accepted.
// Backpressure: byte_ready drops while a word is written and outside a load.
//
// Ports:
//   master_clk, rst         clock and synchronous active-high reset
//   start                   one-cycle load request (honoured in IDLE/DONE/ERROR)
//   byte_in/_valid/_ready   serial program stream: N (16b, MSB first), N words
//   imem_we/addr/wd         instruction-memory write port (one word per write)
//   cpu_hold                holds the processor until a load completes
//   load_done/load_error    result of the most recent load
//
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte (XOR of all data bytes) before a load is declared done.

module program_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [16:0] LP_DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // State entered once all words are in: a checksum byte is expected first
  // when the checksum option is built in.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t LP_TAIL = S_CHK;
`else
  localparam state_t LP_TAIL = S_DONE;
`endif

  state_t              r_state, w_next;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_cnt;
  logic [15:0]         r_word_cnt;
  logic [23:0]         r_shift;
  logic [31:0]         r_wd;
  logic [ADDR_W-1:0]   r_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_rdy;
  logic                w_xfer;
  logic [15:0]         w_len;
  logic                w_len_big;
  logic                w_last;

  assign w_rdy = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (r_state == S_CHK)
`endif
                 ;
  assign w_xfer     = byte_valid && w_rdy;
  // Full length as seen while the low length byte is on the bus.
  assign w_len      = {r_len[15:8], byte_in};
  assign w_len_big  = {1'b0, w_len} > LP_DEPTH;
  assign w_last     = (r_word_cnt + 16'd1) == r_len;

  assign byte_ready = w_rdy;
  assign imem_addr  = r_addr;
  assign imem_wd    = r_wd;

  always_ff @(posedge master_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_HI;
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      S_ERROR: begin
        load_error = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0) w_next = LP_TAIL;
          else if (w_len_big) w_next = S_ERROR;
          else                w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        w_next  = w_last ? LP_TAIL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) w_next = (byte_in == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
      r_wd       <= '0;
      r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // A new load restarts addressing at word 0; r_wd keeps its value.
          if (start) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        S_LEN_HI: if (w_xfer) r_len[15:8] <= byte_in;
        S_LEN_LO: if (w_xfer) r_len[7:0]  <= byte_in;
        S_DATA: begin
          if (w_xfer) begin
            r_shift    <= {r_shift[15:0], byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_wd <= {r_shift, byte_in};
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ byte_in;
`endif
          end
        end
        S_WRITE: begin
          // Address wraps naturally to 0 after the last word of a full memory.
          r_addr     <= r_addr + ADDR_W'(1);
          r_word_cnt <= r_word_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        master_clk = 1'b0;
  logic        rst        = 1'b1;
  logic        start      = 1'b0;
  logic [7:0]  byte_in    = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int w0;

  program_loader #(.ADDR_W(6)) dut (
    .master_clk (master_clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 master_clk = ~master_clk;

  // Count write strobes, sampled away from the active edge.
  always @(negedge master_clk) if (imem_we === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one byte at a negedge and hold it until accepted; optional idle gap
  // afterwards with garbage on byte_in and byte_valid low.
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 8) begin
      @(negedge master_clk);
      n++;
    end
    if (n == 8) chk("rdy_timeout", 32'd0, 32'd1);
    @(negedge master_clk);
    byte_valid = 1'b0;
    if (gap) begin
      byte_in = 8'hEE;
      @(negedge master_clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge master_clk);
    start = 1'b0;
  endtask

  // Finish a load: trailing checksum byte when built in, otherwise just let the
  // WRITE cycle retire.
  task automatic tail(input logic [7:0] cs, input bit after_write);
`ifdef LOADER_CHECKSUM_EN
    send(cs, 1'b0);
`else
    if (cs == 8'hFF) byte_in = 8'h00;
    if (after_write) @(negedge master_clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge master_clk);
    @(negedge master_clk);
    chk("rst_rdy",   32'(byte_ready), 32'd0);
    chk("rst_we",    32'(imem_we),    32'd0);
    chk("rst_addr",  32'(imem_addr),  32'd0);
    chk("rst_wd",    imem_wd,         32'd0);
    chk("rst_hold",  32'(cpu_hold),   32'd1);
    chk("rst_done",  32'(load_done),  32'd0);
    chk("rst_err",   32'(load_error), 32'd0);
    rst = 1'b0;
    @(negedge master_clk);

    // Two-word load
    pulse_start();
    chk("s1_hold", 32'(cpu_hold),   32'd1);
    chk("s1_rdy",  32'(byte_ready), 32'd1);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    chk("s1_we_early", 32'(imem_we), 32'd0);
    send(8'h78, 0);
    chk("s1_we0",   32'(imem_we),   32'd1);
    chk("s1_addr0", 32'(imem_addr), 32'd0);
    chk("s1_wd0",   imem_wd,        32'h12345678);
    @(negedge master_clk);
    chk("s1_we_off", 32'(imem_we),   32'd0);
    chk("s1_addr_i", 32'(imem_addr), 32'd1);
    chk("s1_wd_hold", imem_wd,       32'h12345678);
    send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 0);
    chk("s1_we1",   32'(imem_we),   32'd1);
    chk("s1_addr1", 32'(imem_addr), 32'd1);
    chk("s1_wd1",   imem_wd,        32'h9ABCDEF0);
    tail(8'h00, 1);
    chk("s1_done",  32'(load_done),  32'd1);
    chk("s1_hold0", 32'(cpu_hold),   32'd0);
    chk("s1_err",   32'(load_error), 32'd0);
    chk("s1_addr2", 32'(imem_addr),  32'd2);

    // Zero-length load
    w0 = wr_cnt;
    pulse_start();
    chk("s2_done_clr", 32'(load_done), 32'd0);
    send(8'h00, 0); send(8'h00, 0);
    tail(8'h00, 0);
    chk("s2_done", 32'(load_done), 32'd1);
    chk("s2_hold", 32'(cpu_hold),  32'd0);
    #1 chk("s2_nowr", 32'(wr_cnt - w0), 32'd0);

    // Oversize length; byte offered alongside start must not be consumed in IDLE
    @(negedge master_clk);
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'h00;
    @(negedge master_clk);
    start = 1'b0;
    send(8'h00, 0); send(8'h41, 0);
    chk("s3_err",  32'(load_error), 32'd1);
    chk("s3_hold", 32'(cpu_hold),   32'd1);
    chk("s3_done", 32'(load_done),  32'd0);
    chk("s3_rdy",  32'(byte_ready), 32'd0);
    #1 chk("s3_nowr", 32'(wr_cnt - w0), 32'd0);

    // Gapped valid, with a stray start mid-load
    @(negedge master_clk);
    pulse_start();
    send(8'h00, 1); send(8'h01, 1); send(8'hCA, 1);
    send(8'hFE, 0);
    start = 1'b1;
    @(negedge master_clk);
    start = 1'b0;
    send(8'hBA, 1); send(8'hBE, 0);
    chk("s4_we",   32'(imem_we),   32'd1);
    chk("s4_addr", 32'(imem_addr), 32'd0);
    chk("s4_wd",   imem_wd,        32'hCAFEBABE);
    tail(8'h30, 1);
    chk("s4_done", 32'(load_done), 32'd1);

    // Reset mid-word, then a clean reload
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 0);
    rst = 1'b1;
    @(negedge master_clk);
    chk("s5_hold", 32'(cpu_hold),   32'd1);
    chk("s5_rdy",  32'(byte_ready), 32'd0);
    chk("s5_wd",   imem_wd,         32'd0);
    rst = 1'b0;
    @(negedge master_clk);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("s5_we",   32'(imem_we),   32'd1);
    chk("s5_addr", 32'(imem_addr), 32'd0);
    chk("s5_wd",   imem_wd,        32'h11223344);
    tail(8'h44, 1);
    chk("s5_done", 32'(load_done), 32'd1);

    // Full memory: 64 words, address wraps to 0 afterwards
    #1 w0 = wr_cnt;
    @(negedge master_clk);
    pulse_start();
    send(8'h00, 0); send(8'h40, 0);
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++) send(8'(k), 0);
    chk("s6_we",   32'(imem_we),   32'd1);
    chk("s6_addr", 32'(imem_addr), 32'd63);
    chk("s6_wd",   imem_wd,        32'h3F3F3F3F);
    tail(8'h00, 1);
    chk("s6_wrap", 32'(imem_addr), 32'd0);
    chk("s6_done", 32'(load_done), 32'd1);
    #1 chk("s6_nwr", 32'(wr_cnt - w0), 32'd64);

`ifdef LOADER_CHECKSUM_EN
    // Checksum accept and reject
    @(negedge master_clk);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h04, 0);
    chk("s7_done", 32'(load_done), 32'd1);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0);
    chk("s7_err",  32'(load_error), 32'd1);
    chk("s7_hold", 32'(cpu_hold),   32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
